// File: rtl/adler32_framer.sv
`default_nettype none
// ============================================================================
// Module      : adler32_framer
// Description : Buffers one valid/ready byte frame, then plays it into the
//               adler32 core (size / data_start / data) and returns the sum.
// Revision    : 1.0 - initial release
// ============================================================================
module adler32_framer #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        size_valid,
    output logic [31:0] size,
    output logic        data_start,
    output logic [7:0]  data,
    input  logic        checksum_valid,
    input  logic [31:0] checksum,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        overflow,
    output logic        timeout,
    output logic        busy
);
    localparam int c_cnt_w = ADDR_W + 1;
    localparam int c_tmr_w = $clog2(TIMEOUT + 1);

    localparam logic [2:0] c_fill = 3'd0;
    localparam logic [2:0] c_size = 3'd1;
    localparam logic [2:0] c_gap  = 3'd2;
    localparam logic [2:0] c_send = 3'd3;
    localparam logic [2:0] c_wait = 3'd4;

    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_tmr_w-1:0] c_tmr_end = c_tmr_w'(TIMEOUT - 1);
    localparam logic [3:0]         c_gap_end = 4'(GAP - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_idx;
    logic [3:0]         r_gap_cnt;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_ovf;
    logic [7:0]         r_mem [DEPTH];
    logic [7:0]         r_rd_q;
    logic [31:0]        r_result;
    logic               r_result_valid;

    logic               w_xfer;
    logic               w_full;
    logic               w_close;
    logic               w_last_byte;
    logic               w_expire;
    logic [ADDR_W-1:0]  w_rd_addr;

    assign w_xfer      = in_valid & (r_state == c_fill);
    assign w_full      = (r_count + c_cnt_one) == c_depth;
    assign w_close     = w_xfer & (in_last | w_full);
    assign w_last_byte = r_idx == (r_count - c_cnt_one);
    assign w_expire    = r_timer == c_tmr_end;
    // Read one byte ahead so SEND streams without bubbles; address 0 is
    // preloaded during SIZE/GAP.
    assign w_rd_addr   = (r_state == c_send) ? (r_idx[ADDR_W-1:0] + ADDR_W'(1)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_fill;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_fill:  if (w_close) w_next = c_size;
            c_size:  w_next = (GAP == 0) ? c_send : c_gap;
            c_gap:   if (r_gap_cnt == c_gap_end) w_next = c_send;
            c_send:  if (w_last_byte) w_next = c_wait;
            c_wait:  if (checksum_valid || w_expire) w_next = c_fill;
            default: w_next = c_fill;
        endcase
    end

    always_comb begin
        in_ready   = (r_state == c_fill);
        busy       = (r_state != c_fill);
        size_valid = (r_state == c_size);
        size       = (r_state == c_size) ? 32'(r_count) : 32'd0;
        overflow   = (r_state == c_size) & r_ovf;
        data_start = (r_state == c_send) & (r_idx == '0);
        data       = (r_state == c_send) ? r_rd_q : 8'd0;
        // A checksum arriving on the expiry cycle takes priority.
        timeout    = (r_state == c_wait) & w_expire & ~checksum_valid;
    end

    assign result_valid = r_result_valid;
    assign result       = r_result;

    always_ff @(posedge clk) begin
        if (w_xfer) r_mem[r_count[ADDR_W-1:0]] <= in_data;
        r_rd_q <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_idx          <= '0;
            r_gap_cnt      <= '0;
            r_timer        <= '0;
            r_ovf          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                c_fill: begin
                    if (w_xfer) begin
                        r_count <= r_count + c_cnt_one;
                        r_ovf   <= w_full & ~in_last;
                    end
                end
                c_size: begin
                    r_gap_cnt <= '0;
                    r_idx     <= '0;
                end
                c_gap:  r_gap_cnt <= r_gap_cnt + 4'd1;
                c_send: begin
                    r_idx   <= r_idx + c_cnt_one;
                    r_timer <= '0;
                end
                c_wait: begin
                    r_timer <= r_timer + c_tmr_w'(1);
                    if (checksum_valid) begin
                        r_result       <= checksum;
                        r_result_valid <= 1'b1;
                    end
                    if (checksum_valid || w_expire) r_count <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adler32_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adler32_framer
// Description : Directed bench for adler32_framer with a small core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adler32_framer;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 16;
    localparam int T       = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        size_valid;
    logic [31:0] size;
    logic        data_start;
    logic [7:0]  data;
    logic        checksum_valid;
    logic [31:0] checksum;
    logic        result_valid;
    logic [31:0] result;
    logic        overflow;
    logic        timeout;
    logic        busy;

    adler32_framer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .size_valid(size_valid), .size(size), .data_start(data_start), .data(data),
        .checksum_valid(checksum_valid), .checksum(checksum),
        .result_valid(result_valid), .result(result),
        .overflow(overflow), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        string       s;
        int          exp_size;
        logic [31:0] exp_res;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Monitor / core-model state
    logic [31:0] sv_q [$];
    logic [31:0] res_q [$];
    bit  col = 0, pend = 0, mute = 0, stray = 0;
    int  got = 0, exp_len = 0, dly = 0, ca = 1, cb = 0;
    int  ds_n = 0, ovf_n = 0, to_n = 0, ds_err = 0, data_err = 0, rdy_err = 0;
    time sv_t, ds_t, last_t, to_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Observes the core interface and answers like an adler32 core 3 cycles
    // after the last byte, unless muted.
    initial begin
        checksum_valid = 1'b0;
        checksum       = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                col = 0; pend = 0; checksum_valid = 1'b0;
                continue;
            end
            checksum_valid = 1'b0;
            if (size_valid) begin sv_q.push_back(size); sv_t = $time; exp_len = int'(size); end
            if (overflow) ovf_n++;
            if (timeout) begin to_n++; to_t = $time; end
            if (result_valid) res_q.push_back(result);
            if (busy == in_ready) rdy_err++;
            if (data_start) begin
                if (col) ds_err++;
                ds_n++; ds_t = $time; col = 1; got = 0; ca = 1; cb = 0;
            end
            if (col) begin
                ca = (ca + int'(data)) % 65521;
                cb = (cb + ca) % 65521;
                got++;
                if (got == exp_len) begin col = 0; last_t = $time; pend = 1; dly = 3; end
            end else if (data != 8'd0) begin
                data_err++;
            end
            if (pend) begin
                if (dly == 0) begin
                    pend = 0;
                    if (!mute) begin checksum_valid = 1'b1; checksum = {cb[15:0], ca[15:0]}; end
                end else dly--;
            end
            if (stray) begin checksum_valid = 1'b1; checksum = 32'hDEADBEEF; stray = 0; end
        end
    end

    task automatic drive(input bq_t q, input logic [31:0] lm, output time lt);
        lt = 0;
        for (int i = 0; i < q.size(); i++) begin
            int n = 0;
            in_valid = 1'b1; in_data = q[i]; in_last = lm[i];
            while (!in_ready && n < 200) begin @(negedge clk); n++; end
            if (!in_ready) begin
                errors++; checks++;
                $display("FAIL in_ready_wait: got in_ready=0 after %0d cycles, required 1", n);
                break;
            end
            lt = $time;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_res(input int n, input string name);
        int k = 0;
        while (res_q.size() < n && k < 400) begin @(negedge clk); k++; end
        if (res_q.size() < n) begin
            errors++; checks++;
            $display("FAIL %s: got %0d results, required %0d", name, res_q.size(), n);
        end
    endtask

    function automatic bq_t to_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    initial begin
        vec_t vecs [4];
        bq_t  q;
        time  lt;
        int   k;

        vecs[0] = '{s: "a",         exp_size: 1, exp_res: 32'h00620062};
        vecs[1] = '{s: "ab",        exp_size: 2, exp_res: 32'h012600C4};
        vecs[2] = '{s: "abc",       exp_size: 3, exp_res: 32'h024D0127};
        vecs[3] = '{s: "Wikipedia", exp_size: 9, exp_res: 32'h11E60398};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", {28'd0, size_valid, data_start, result_valid, overflow | timeout}, 32'd0);
        chk("rst_size", size, 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 4; n++) begin
            sv_q.delete(); res_q.delete(); ds_n = 0; ovf_n = 0;
            q = to_q(vecs[n].s);
            drive(q, 32'd1 << (q.size() - 1), lt);
            wait_res(1, "vec_result_wait");
            chk($sformatf("vec%0d_size", n), sv_q.size() > 0 ? sv_q[0] : 32'hFFFFFFFF, 32'(vecs[n].exp_size));
            chk($sformatf("vec%0d_result", n), res_q.size() > 0 ? res_q[0] : 32'hFFFFFFFF, vecs[n].exp_res);
            chk($sformatf("vec%0d_starts", n), 32'(ds_n), 32'd1);
            chk($sformatf("vec%0d_overflow", n), 32'(ovf_n), 32'd0);
            chk($sformatf("vec%0d_lat_size", n), 32'(sv_t - lt), 32'(T));
            chk($sformatf("vec%0d_lat_start", n), 32'(ds_t - lt), 32'((2 + GAP) * T));
            chk($sformatf("vec%0d_lat_last", n), 32'(last_t - lt), 32'((1 + GAP + vecs[n].exp_size) * T));
        end

        // 18 bytes with last only on the 18th: forced close at DEPTH, then 2-byte frame
        sv_q.delete(); res_q.delete(); ovf_n = 0;
        q.delete();
        for (int i = 0; i < 18; i++) q.push_back(8'(i + 1));
        drive(q, 32'd1 << 17, lt);
        wait_res(2, "ovf_result_wait");
        chk("ovf_size1", sv_q.size() > 0 ? sv_q[0] : 32'hFFFFFFFF, 32'd16);
        chk("ovf_size2", sv_q.size() > 1 ? sv_q[1] : 32'hFFFFFFFF, 32'd2);
        chk("ovf_pulses", 32'(ovf_n), 32'd1);
        chk("ovf_result1", res_q.size() > 0 ? res_q[0] : 32'hFFFFFFFF, 32'h03400089);
        chk("ovf_result2", res_q.size() > 1 ? res_q[1] : 32'hFFFFFFFF, 32'h00360024);

        // Silent core: timeout pulse, result held
        mute = 1; to_n = 0; res_q.delete();
        drive(to_q("abc"), 32'd4, lt);
        k = 0;
        while (to_n == 0 && k < 100) begin @(negedge clk); k++; end
        chk("to_pulses", 32'(to_n), 32'd1);
        chk("to_latency", 32'(to_t - last_t), 32'(TIMEOUT * T));
        @(negedge clk);
        #1;
        chk("to_busy_after", 32'(busy), 32'd0);
        chk("to_result_held", result, 32'h00360024);
        chk("to_no_result", 32'(res_q.size()), 32'd0);
        mute = 0;

        // Stray checksum while idle must be ignored
        stray = 1;
        repeat (5) @(negedge clk);
        chk("stray_no_result", 32'(res_q.size()), 32'd0);
        chk("stray_result_held", result, 32'h00360024);

        res_q.delete();
        drive(to_q("ab"), 32'd2, lt);
        wait_res(1, "post_to_wait");
        chk("post_to_result", res_q.size() > 0 ? res_q[0] : 32'hFFFFFFFF, 32'h012600C4);

        // Reset while the third byte of 9 is on the data bus
        res_q.delete();
        drive(to_q("Wikipedia"), 32'd1 << 8, lt);
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!(col && got == 3) && k < 100);
        chk("mid_reached_byte3", 32'(got), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", 32'(data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sv_q.delete(); res_q.delete();
        @(negedge clk);
        drive(to_q("ab"), 32'd2, lt);
        wait_res(1, "mid_result_wait");
        repeat (30) @(negedge clk);
        chk("mid_results", 32'(res_q.size()), 32'd1);
        chk("mid_size", sv_q.size() > 0 ? sv_q[0] : 32'hFFFFFFFF, 32'd2);
        chk("mid_result", res_q.size() > 0 ? res_q[0] : 32'hFFFFFFFF, 32'h012600C4);

        // Back-to-back frames, in_valid held high across both
        sv_q.delete(); res_q.delete();
        drive(to_q("abcab"), 32'b10100, lt);
        wait_res(2, "b2b_result_wait");
        chk("b2b_size1", sv_q.size() > 0 ? sv_q[0] : 32'hFFFFFFFF, 32'd3);
        chk("b2b_size2", sv_q.size() > 1 ? sv_q[1] : 32'hFFFFFFFF, 32'd2);
        chk("b2b_result1", res_q.size() > 0 ? res_q[0] : 32'hFFFFFFFF, 32'h024D0127);
        chk("b2b_result2", res_q.size() > 1 ? res_q[1] : 32'hFFFFFFFF, 32'h012600C4);

        chk("data_start_repeats", 32'(ds_err), 32'd0);
        chk("data_outside_send", 32'(data_err), 32'd0);
        chk("in_ready_vs_busy", 32'(rdy_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
